// File: rtl/vx_rf_bank_arbiter.sv
// Per-bank round-robin read arbiter for a banked register file.
// Writebacks take priority, and read responses return one cycle after the grant.
module vx_rf_bank_arbiter #(
  parameter int unsigned NUM_REQS    = 4,
  parameter int unsigned NUM_BANKS   = 4,
  parameter int unsigned BANK_ADDR_W = 6,
  parameter int unsigned TAG_W       = 4,
  parameter int unsigned PERF_W      = 16,
  localparam int unsigned BANK_W     = $clog2(NUM_BANKS),
  localparam int unsigned REQ_W      = $clog2(NUM_REQS)
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_REQS-1:0]             req_valid,
  input  logic [NUM_REQS*BANK_W-1:0]      req_bank,
  input  logic [NUM_REQS*BANK_ADDR_W-1:0] req_addr,
  input  logic [NUM_REQS*TAG_W-1:0]       req_tag,
  output logic [NUM_REQS-1:0]             req_ready,
  input  logic                            wb_valid,
  input  logic [BANK_W-1:0]               wb_bank,
  output logic [NUM_BANKS-1:0]            rd_en,
  output logic [NUM_BANKS*BANK_ADDR_W-1:0] rd_addr,
  output logic [NUM_REQS-1:0]             rsp_valid,
  output logic [NUM_REQS*TAG_W-1:0]       rsp_tag,
  output logic [PERF_W-1:0]               perf_conflicts
);

  logic [NUM_BANKS-1:0][REQ_W-1:0] ptr;
  logic [NUM_BANKS-1:0][REQ_W-1:0] gnt_idx;
  logic [NUM_BANKS-1:0]            gnt_hit;
  logic                            conflict_c;

  // Each bank searches upward from its pointer; a writeback on the bank suppresses reads.
  always_comb begin
    logic [REQ_W-1:0] idx;
    idx       = '0;
    gnt_hit   = '0;
    gnt_idx   = '0;
    req_ready = '0;
    rd_en     = '0;
    rd_addr   = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      if (!reset && !(wb_valid && wb_bank == BANK_W'(b))) begin
        for (int unsigned k = 0; k < NUM_REQS; k++) begin
          idx = REQ_W'((32'(ptr[b]) + k) % NUM_REQS);
          if (!gnt_hit[b] && req_valid[idx] &&
              req_bank[idx*BANK_W +: BANK_W] == BANK_W'(b)) begin
            gnt_hit[b] = 1'b1;
            gnt_idx[b] = idx;
          end
        end
      end
      if (gnt_hit[b]) begin
        rd_en[b]                                 = 1'b1;
        rd_addr[b*BANK_ADDR_W +: BANK_ADDR_W]    = req_addr[gnt_idx[b]*BANK_ADDR_W +: BANK_ADDR_W];
        req_ready[gnt_idx[b]]                    = 1'b1;
      end
    end
    conflict_c = |(req_valid & ~req_ready);
  end

  // Pointer advance, one-cycle response pipeline and saturating conflict counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr            <= '0;
      rsp_valid      <= '0;
      rsp_tag        <= '0;
      perf_conflicts <= '0;
    end else begin
      for (int b = 0; b < NUM_BANKS; b++) begin
        if (gnt_hit[b]) begin
          ptr[b] <= (gnt_idx[b] == REQ_W'(NUM_REQS - 1)) ? '0 : gnt_idx[b] + 1'b1;
        end
      end
      rsp_valid <= req_ready;
      for (int i = 0; i < NUM_REQS; i++) begin
        if (req_ready[i]) begin
          rsp_tag[i*TAG_W +: TAG_W] <= req_tag[i*TAG_W +: TAG_W];
        end
      end
      if (conflict_c && perf_conflicts != '1) begin
        perf_conflicts <= perf_conflicts + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_vx_rf_bank_arbiter.sv
// Bench for vx_rf_bank_arbiter: vector table with a response scoreboard,
// plus hand-written reset and saturation sequences.
module tb_vx_rf_bank_arbiter;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid;
  logic [7:0]  req_bank;
  logic [23:0] req_addr;
  logic [15:0] req_tag;
  logic [3:0]  req_ready;
  logic        wb_valid;
  logic [1:0]  wb_bank;
  logic [3:0]  rd_en;
  logic [23:0] rd_addr;
  logic [3:0]  rsp_valid;
  logic [15:0] rsp_tag;
  logic [15:0] perf_conflicts;

  logic [3:0]  req_ready4;
  logic [3:0]  rd_en4;
  logic [23:0] rd_addr4;
  logic [3:0]  rsp_valid4;
  logic [15:0] rsp_tag4;
  logic [3:0]  perf4;

  int n_tests = 0;
  int n_fail  = 0;

  vx_rf_bank_arbiter u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_bank(req_bank),
    .req_addr(req_addr), .req_tag(req_tag), .req_ready(req_ready),
    .wb_valid(wb_valid), .wb_bank(wb_bank), .rd_en(rd_en), .rd_addr(rd_addr),
    .rsp_valid(rsp_valid), .rsp_tag(rsp_tag), .perf_conflicts(perf_conflicts)
  );

  vx_rf_bank_arbiter #(.PERF_W(4)) u_dut4 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_bank(req_bank),
    .req_addr(req_addr), .req_tag(req_tag), .req_ready(req_ready4),
    .wb_valid(wb_valid), .wb_bank(wb_bank), .rd_en(rd_en4), .rd_addr(rd_addr4),
    .rsp_valid(rsp_valid4), .rsp_tag(rsp_tag4), .perf_conflicts(perf4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  valid;
    logic [7:0]  bank;
    logic [23:0] addr;
    logic [15:0] tag;
    logic        wbv;
    logic [1:0]  wbb;
    logic [3:0]  ready;
    logic [3:0]  rden;
    logic [23:0] rdaddr;
  } vec_t;

  typedef struct {
    logic [3:0]  valid;
    logic [15:0] tag;
  } rsp_t;

  localparam int NV = 18;
  vec_t vecs [NV];
  rsp_t sb_q [$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] v, input logic [7:0] bk, input logic [23:0] ad,
                              input logic [15:0] tg, input logic wv, input logic [1:0] wb,
                              input logic [3:0] rdy, input logic [3:0] re, input logic [23:0] ra);
    vec_t r;
    r.valid = v; r.bank = bk; r.addr = ad; r.tag = tg; r.wbv = wv; r.wbb = wb;
    r.ready = rdy; r.rden = re; r.rdaddr = ra;
    return r;
  endfunction

  // Held requests must keep their payload until granted.
  logic [3:0]  pend;
  logic [7:0]  p_bank;
  logic [23:0] p_addr;
  logic [15:0] p_tag;
  initial pend = '0;
  always @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        if (pend[i]) begin
          chk("sticky", {req_valid[i], req_bank[i*2 +: 2], req_addr[i*6 +: 6], req_tag[i*4 +: 4]},
                        {1'b1, p_bank[i*2 +: 2], p_addr[i*6 +: 6], p_tag[i*4 +: 4]});
        end
      end
      pend = req_valid & ~req_ready;
    end else begin
      pend = '0;
    end
    p_bank = req_bank; p_addr = req_addr; p_tag = req_tag;
  end

  initial begin
    logic [15:0] tag_hold;
    int          perf_m;
    int          perf_m4;
    rsp_t        e;
    rsp_t        got;

    vecs[0]  = mk(4'hf, 8'haa, {6'd13,6'd12,6'd11,6'd10}, 16'hba98, 0, 0, 4'h1, 4'h4, {6'd0,6'd10,6'd0,6'd0});
    vecs[1]  = mk(4'he, 8'haa, {6'd13,6'd12,6'd11,6'd10}, 16'hba98, 0, 0, 4'h2, 4'h4, {6'd0,6'd11,6'd0,6'd0});
    vecs[2]  = mk(4'hc, 8'haa, {6'd13,6'd12,6'd11,6'd10}, 16'hba98, 0, 0, 4'h4, 4'h4, {6'd0,6'd12,6'd0,6'd0});
    vecs[3]  = mk(4'h8, 8'haa, {6'd13,6'd12,6'd11,6'd10}, 16'hba98, 0, 0, 4'h8, 4'h4, {6'd0,6'd13,6'd0,6'd0});
    vecs[4]  = mk(4'h3, 8'b00_00_01_00, {6'd0,6'd0,6'd9,6'd5}, 16'h0021, 0, 0, 4'h3, 4'h3, {6'd0,6'd0,6'd9,6'd5});
    vecs[5]  = mk(4'h4, 8'b00_11_00_00, {6'd0,6'd7,6'd0,6'd0}, 16'h0500, 1, 3, 4'h0, 4'h0, 24'd0);
    vecs[6]  = mk(4'h4, 8'b00_11_00_00, {6'd0,6'd7,6'd0,6'd0}, 16'h0500, 1, 3, 4'h0, 4'h0, 24'd0);
    vecs[7]  = mk(4'h4, 8'b00_11_00_00, {6'd0,6'd7,6'd0,6'd0}, 16'h0500, 0, 0, 4'h4, 4'h8, {6'd7,6'd0,6'd0,6'd0});
    vecs[8]  = mk(4'ha, 8'b11_00_11_00, {6'd20,6'd0,6'd21,6'd0}, 16'hc0d0, 0, 0, 4'h8, 4'h8, {6'd20,6'd0,6'd0,6'd0});
    vecs[9]  = mk(4'h2, 8'b11_00_11_00, {6'd20,6'd0,6'd21,6'd0}, 16'hc0d0, 0, 0, 4'h2, 4'h8, {6'd21,6'd0,6'd0,6'd0});
    vecs[10] = mk(4'h2, 8'b00_00_01_00, {6'd0,6'd0,6'd30,6'd0}, 16'h00e0, 1, 0, 4'h2, 4'h2, {6'd0,6'd0,6'd30,6'd0});
    vecs[11] = mk(4'h9, 8'h00, {6'd40,6'd0,6'd0,6'd41}, 16'h3001, 0, 0, 4'h8, 4'h1, {6'd0,6'd0,6'd0,6'd40});
    vecs[12] = mk(4'h1, 8'h00, {6'd40,6'd0,6'd0,6'd41}, 16'h3001, 0, 0, 4'h1, 4'h1, {6'd0,6'd0,6'd0,6'd41});
    vecs[13] = mk(4'hf, 8'b10_11_00_01, {6'd50,6'd51,6'd52,6'd53}, 16'h4567, 1, 2, 4'h7, 4'hb, {6'd51,6'd0,6'd53,6'd52});
    vecs[14] = mk(4'h8, 8'b10_11_00_01, {6'd50,6'd51,6'd52,6'd53}, 16'h4567, 0, 0, 4'h8, 4'h4, {6'd0,6'd50,6'd0,6'd0});
    vecs[15] = mk(4'h0, 8'h00, 24'd0, 16'h0000, 0, 0, 4'h0, 4'h0, 24'd0);
    vecs[16] = mk(4'h1, 8'h00, {6'd0,6'd0,6'd0,6'd1}, 16'h0002, 0, 0, 4'h1, 4'h1, {6'd0,6'd0,6'd0,6'd1});
    vecs[17] = mk(4'h1, 8'h00, {6'd0,6'd0,6'd0,6'd2}, 16'h0003, 0, 0, 4'h1, 4'h1, {6'd0,6'd0,6'd0,6'd2});

    // Reset state, with requests present to show reset blocks grants.
    reset = 1'b1; wb_valid = 1'b0; wb_bank = '0;
    req_valid = 4'hf; req_bank = '0; req_addr = '0; req_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("reset_rsp_tag", 64'(rsp_tag), 64'h0);
    chk("reset_perf", 64'(perf_conflicts), 64'h0);
    chk("reset_ready", 64'(req_ready), 64'h0);
    chk("reset_rd_en", 64'(rd_en), 64'h0);
    req_valid = '0;
    reset = 1'b0;

    tag_hold = '0; perf_m = 0; perf_m4 = 0;
    for (int v = 0; v < NV; v++) begin
      req_valid = vecs[v].valid; req_bank = vecs[v].bank; req_addr = vecs[v].addr;
      req_tag = vecs[v].tag; wb_valid = vecs[v].wbv; wb_bank = vecs[v].wbb;
      #2;
      chk($sformatf("v%0d_ready", v), 64'(req_ready), 64'(vecs[v].ready));
      chk($sformatf("v%0d_rd_en", v), 64'(rd_en), 64'(vecs[v].rden));
      chk($sformatf("v%0d_rd_addr", v), 64'(rd_addr), 64'(vecs[v].rdaddr));
      for (int i = 0; i < 4; i++)
        if (vecs[v].ready[i]) tag_hold[i*4 +: 4] = vecs[v].tag[i*4 +: 4];
      e.valid = vecs[v].ready; e.tag = tag_hold;
      sb_q.push_back(e);
      if (|(vecs[v].valid & ~vecs[v].ready)) begin
        if (perf_m < 65535) perf_m++;
        if (perf_m4 < 15) perf_m4++;
      end
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      got.valid = rsp_valid; got.tag = rsp_tag;
      chk($sformatf("v%0d_rsp_valid", v), 64'(got.valid), 64'(e.valid));
      chk($sformatf("v%0d_rsp_tag", v), 64'(got.tag), 64'(e.tag));
      chk($sformatf("v%0d_perf", v), 64'(perf_conflicts), 64'(perf_m));
      chk($sformatf("v%0d_perf4", v), 64'(perf4), 64'(perf_m4));
    end

    // Reset landing between edges right after a grant drops the response.
    req_valid = 4'h1; req_bank = '0; req_addr = {18'd0, 6'd3}; req_tag = 16'h0005; wb_valid = 1'b0;
    #2;
    chk("rst_seq_grant", 64'(req_ready), 64'h1);
    @(posedge clk);
    #1;
    chk("rst_seq_rsp_before", 64'({rsp_valid, rsp_tag[3:0]}), 64'h15);
    req_valid = 4'h0;
    #2;
    reset = 1'b1;
    req_valid = 4'hf; req_addr = {6'd4, 6'd3, 6'd2, 6'd1}; req_tag = 16'h9876;
    #1;
    chk("rst_seq_rsp_valid", 64'(rsp_valid), 64'h0);
    chk("rst_seq_rsp_tag", 64'(rsp_tag), 64'h0);
    chk("rst_seq_perf", 64'(perf_conflicts), 64'h0);
    chk("rst_seq_ready", 64'(req_ready), 64'h0);
    chk("rst_seq_rd_en", 64'(rd_en), 64'h0);
    #2;
    reset = 1'b0;
    #1;
    chk("rst_seq_ptr_cleared", 64'(req_ready), 64'h1);
    chk("rst_seq_rd_addr", 64'(rd_addr), 64'(24'd1));
    @(posedge clk);
    #1;
    chk("rst_seq_perf_after", 64'(perf_conflicts), 64'h1);
    chk("rst_seq_rsp_after", 64'({rsp_valid, rsp_tag}), 64'h10006);

    // Long writeback block saturates the narrow counter.
    reset = 1'b1;
    req_valid = 4'h1; req_bank = 8'b00_00_00_01; req_addr = {18'd0, 6'd33}; req_tag = 16'h000a;
    wb_valid = 1'b1; wb_bank = 2'd1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    for (int n = 1; n <= 20; n++) begin
      #2;
      chk($sformatf("sat_ready_%0d", n), 64'({req_ready, rd_en}), 64'h0);
      @(posedge clk);
      #1;
      chk($sformatf("sat_perf4_%0d", n), 64'(perf4), 64'((n < 15) ? n : 15));
    end
    chk("sat_perf16", 64'(perf_conflicts), 64'd20);
    wb_valid = 1'b0;
    #2;
    chk("sat_release_ready", 64'(req_ready), 64'h1);
    chk("sat_release_rd", 64'({rd_en, rd_addr}), 64'({4'h2, 6'd0, 6'd0, 6'd33, 6'd0}));
    @(posedge clk);
    #1;
    req_valid = 4'h0;
    chk("sat_release_rsp", 64'({rsp_valid, rsp_tag}), 64'h1000a);
    chk("sat_perf4_hold", 64'(perf4), 64'd15);

    @(posedge clk);
    #1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
